// File: rtl/fp_mul_stream.sv
// fp_mul_stream: valid/ready wrapper around a fixed-latency fp_mul with credit-guarded result FIFO.
// Optional tag path enabled by defining FP_MUL_STREAM_TAG_EN.
module fp_mul_stream #(
    parameter int WIDTH      = 16,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8
`ifdef FP_MUL_STREAM_TAG_EN
    ,
    parameter int TAG_W      = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_rm,
`ifdef FP_MUL_STREAM_TAG_EN
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] out_tag,
`endif
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic [2:0]       mul_rm,
    input  logic [WIDTH-1:0] mul_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [LATENCY-1:0] vpipe;
    logic [CW-1:0]      occ_q;
    logic [CW-1:0]      cnt_q;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [WIDTH-1:0]   mem [FIFO_DEPTH];
    logic               issue;
    logic               pop;
    logic               wr;
    logic               empty;
    logic               full;

    // credit check uses only the registered occupancy, so out_ready never reaches in_ready
    assign in_ready  = occ_q < CW'(FIFO_DEPTH);
    assign issue     = in_valid && in_ready;
    assign wr        = vpipe[LATENCY-1];
    assign empty     = cnt_q == '0;
    assign full      = cnt_q == CW'(FIFO_DEPTH);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = empty ? '0 : mem[rd_ptr];
    assign mul_a     = in_a;
    assign mul_b     = in_b;
    assign mul_rm    = in_rm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe  <= '0;
            occ_q  <= '0;
            cnt_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            vpipe  <= LATENCY'({vpipe, issue});
            occ_q  <= occ_q + CW'(issue) - CW'(pop);
            cnt_q  <= cnt_q + CW'(wr) - CW'(pop);
            wr_ptr <= wr ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= mul_result;
    end

`ifdef FP_MUL_STREAM_TAG_EN
    logic [TAG_W-1:0] tpipe [LATENCY];
    logic [TAG_W-1:0] tmem  [FIFO_DEPTH];

    assign out_tag = empty ? '0 : tmem[rd_ptr];

    always_ff @(posedge clk) begin
        tpipe[0] <= in_tag;
        for (int i = 1; i < LATENCY; i++) tpipe[i] <= tpipe[i-1];
        if (wr) tmem[wr_ptr] <= tpipe[LATENCY-1];
    end
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr && full && !pop));
endmodule
